// File: rtl/lmc_pkg.sv
// Shared definitions for the LMC stream blocks: FSM encoding and RAM depth helper.
package lmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned depth(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry first-word-fall-through FIFO with push/pop/flush and an occupancy count.
module stream_fifo2 #(
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [M-1:0] push_data,
  output logic [M-1:0] head,
  output logic [1:0]   count
);

  logic [M-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && (count != 2'd2);
  assign pop_ok  = pop && (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // Storage is not reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ram_stream_reader.sv
// Reads a contiguous, wrapping run of RAM words and delivers them as a valid/ready stream.
module ram_stream_reader
  import lmc_pkg::*;
#(
  parameter int N = 2,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] base_adr,
  input  logic [N:0]   count,
  output logic [N-1:0] ram_adr,
  output logic         ram_rd_en,
  input  logic [M-1:0] ram_data,
  output logic [M-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         done
);

  state_t       state;
  state_t       next_state;
  logic [N-1:0] base;
  logic [N:0]   len;
  logic [N:0]   reads_issued;
  logic [N:0]   words_sent;
  logic         in_flight;
  logic [1:0]   fifo_count;
  logic [2:0]   occupancy;
  logic         issue;
  logic         flush;
  logic         push;
  logic         pop;
  logic         is_last;

  assign pop       = out_valid && out_ready;
  assign is_last   = (words_sent == len - (N+1)'(1));
  assign occupancy = {1'b0, fifo_count} + {2'b0, in_flight} - {2'b0, pop};
  // A return landing in the abort cycle is dropped rather than buffered.
  assign push      = in_flight && (state == RUN) && !abort;

  always_comb begin
    next_state = state;
    issue      = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = RUN;
      end
      RUN: begin
        if (abort) begin
          next_state = IDLE;
          flush      = 1'b1;
        end else begin
          issue = (reads_issued < len) && (occupancy < 3'd2);
          if (pop && is_last) next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base         <= '0;
      len          <= '0;
      reads_issued <= '0;
      words_sent   <= '0;
      in_flight    <= 1'b0;
    end else begin
      state     <= next_state;
      in_flight <= issue;
      if (state == IDLE && start) begin
        base         <= base_adr;
        len          <= (count == '0) ? (N+1)'(depth(N)) : count;
        reads_issued <= '0;
        words_sent   <= '0;
      end else if (state == RUN) begin
        if (issue) reads_issued <= reads_issued + (N+1)'(1);
        if (pop)   words_sent   <= words_sent + (N+1)'(1);
      end
    end
  end

  stream_fifo2 #(.M(M)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (ram_data),
    .head      (out_data),
    .count     (fifo_count)
  );

  assign ram_adr   = base + reads_issued[N-1:0];
  assign ram_rd_en = issue;
  assign out_valid = (fifo_count != 2'd0);
  assign out_last  = out_valid && is_last;
  assign busy      = (state == RUN);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader against a 1-cycle-latency RAM model.
module tb_ram_stream_reader;

  localparam int N = 2;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b0;
  logic [N-1:0] base_adr = '0;
  logic [N:0]   count = '0;
  logic [N-1:0] ram_adr;
  logic         ram_rd_en;
  logic [M-1:0] ram_data = '0;
  logic [M-1:0] out_data;
  logic         out_valid;
  logic         out_last;
  logic         busy;
  logic         done;

  logic [M-1:0] mem [4];

  int tests = 0;
  int fails = 0;

  logic [M-1:0] got_data [$];
  logic         got_last [$];
  logic [N-1:0] adr_log [$];
  int           first_valid;
  int           done_cyc;
  int           stall_changes;
  int           max_outst;
  logic         done_busy;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_rd_en) ram_data <= mem[ram_adr];
  end

  ram_stream_reader #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .base_adr  (base_adr),
    .count     (count),
    .ram_adr   (ram_adr),
    .ram_rd_en (ram_rd_en),
    .ram_data  (ram_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Runs one transfer; inputs change at negedge, outputs sampled 1 ns later.
  task automatic run_xfer(input logic [N-1:0] b, input logic [N:0] c,
                          input bit toggle, input bit restart);
    int issued = 0;
    int popped = 0;
    logic held = 1'b0;
    logic [M-1:0] held_data = '0;
    got_data.delete();
    got_last.delete();
    adr_log.delete();
    first_valid = -1;
    done_cyc = -1;
    stall_changes = 0;
    max_outst = 0;
    done_busy = 1'b1;
    @(negedge clk);
    start = 1'b1; base_adr = b; count = c; out_ready = 1'b1;
    #1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      start = restart && (cyc == 1);
      if (restart && cyc == 1) begin
        base_adr = 2'd3;
        count = 3'd0;
      end
      out_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
      #1;
      if (held && (!out_valid || out_data !== held_data)) stall_changes++;
      if (ram_rd_en) begin
        issued++;
        adr_log.push_back(ram_adr);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
        popped++;
      end
      if (issued - popped > max_outst) max_outst = issued - popped;
      held = out_valid && !out_ready;
      held_data = out_data;
      if (done) begin
        done_cyc = cyc;
        done_busy = busy;
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({ram_adr, ram_rd_en, out_data, out_valid, out_last, busy, done} !== 12'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required all zero",
               {ram_adr, ram_rd_en, out_data, out_valid, out_last, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_read();
    logic [M-1:0] exp [4] = '{4'hA, 4'h3, 4'h7, 4'hC};
    run_xfer(2'd0, 3'd4, 1'b0, 1'b0);
    tests++;
    if (first_valid !== 3) begin
      fails++; $display("FAIL full_first_valid: got cycle %0d required 3", first_valid);
    end
    tests++;
    if (got_data.size() !== 4) begin
      fails++; $display("FAIL full_len: got %0d words required 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_data[i] !== exp[i] || got_last[i] !== (i == 3)) begin
          fails++;
          $display("FAIL full_word%0d: got %h last %b required %h last %b",
                   i, got_data[i], got_last[i], exp[i], (i == 3));
        end
      end
    end
    tests++;
    if (done_cyc !== 7 || done_busy !== 1'b0) begin
      fails++; $display("FAIL full_done: got cycle %0d busy %b required 7 busy 0", done_cyc, done_busy);
    end
    @(negedge clk); #1;
    tests++;
    if ({done, busy, out_valid} !== 3'b000) begin
      fails++; $display("FAIL full_after_done: got done/busy/valid %b required 000", {done, busy, out_valid});
    end
  endtask

  task automatic test_wrap();
    run_xfer(2'd3, 3'd2, 1'b0, 1'b0);
    tests++;
    if (adr_log.size() !== 2 || adr_log[0] !== 2'd3 || adr_log[1] !== 2'd0) begin
      fails++; $display("FAIL wrap_adr: got %p required 3,0", adr_log);
    end
    tests++;
    if (got_data.size() !== 2 || got_data[0] !== 4'hC || got_data[1] !== 4'hA ||
        got_last[0] !== 1'b0 || got_last[1] !== 1'b1) begin
      fails++; $display("FAIL wrap_data: got %p last %p required C,A last 0,1", got_data, got_last);
    end
    tests++;
    if (done_cyc < 0) begin
      fails++; $display("FAIL wrap_done: got no done pulse required one");
    end
  endtask

  task automatic test_count_zero();
    logic [M-1:0] exp [4] = '{4'h3, 4'h7, 4'hC, 4'hA};
    run_xfer(2'd1, 3'd0, 1'b0, 1'b0);
    tests++;
    if (got_data.size() !== 4) begin
      fails++; $display("FAIL zero_len: got %0d words required 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_data[i] !== exp[i] || got_last[i] !== (i == 3)) begin
          fails++;
          $display("FAIL zero_word%0d: got %h last %b required %h last %b",
                   i, got_data[i], got_last[i], exp[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [M-1:0] exp [4] = '{4'hA, 4'h3, 4'h7, 4'hC};
    run_xfer(2'd0, 3'd4, 1'b1, 1'b0);
    tests++;
    if (got_data.size() !== 4) begin
      fails++; $display("FAIL bp_len: got %0d words required 4", got_data.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_data[i] !== exp[i] || got_last[i] !== (i == 3)) begin
          fails++;
          $display("FAIL bp_word%0d: got %h last %b required %h last %b",
                   i, got_data[i], got_last[i], exp[i], (i == 3));
        end
      end
    end
    tests++;
    if (stall_changes !== 0) begin
      fails++; $display("FAIL bp_stable: got %0d changes while stalled required 0", stall_changes);
    end
    tests++;
    if (max_outst > 2) begin
      fails++; $display("FAIL bp_occupancy: got %0d outstanding required <= 2", max_outst);
    end
    tests++;
    if (done_cyc < 0) begin
      fails++; $display("FAIL bp_done: got no done pulse required one");
    end
  endtask

  task automatic test_abort();
    bit saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; base_adr = 2'd0; count = 3'd4; out_ready = 1'b1;
    #1;
    repeat (2) begin
      @(negedge clk); start = 1'b0; #1;
    end
    @(negedge clk); #1;
    tests++;
    if ({out_valid, out_data} !== {1'b1, 4'hA}) begin
      fails++; $display("FAIL abort_first_word: got valid %b data %h required 1 A", out_valid, out_data);
    end
    @(negedge clk); abort = 1'b1; #1;
    @(negedge clk); abort = 1'b0; #1;
    tests++;
    if ({out_valid, busy, done} !== 3'b000) begin
      fails++; $display("FAIL abort_stop: got valid/busy/done %b required 000", {out_valid, busy, done});
    end
    repeat (3) begin
      @(negedge clk); #1;
      if (done || out_valid) saw_done = 1'b1;
    end
    tests++;
    if (saw_done) begin
      fails++; $display("FAIL abort_quiet: got done or valid after abort required none");
    end
    out_ready = 1'b0;
    run_xfer(2'd2, 3'd1, 1'b0, 1'b0);
    tests++;
    if (got_data.size() !== 1 || got_data[0] !== 4'h7 || got_last[0] !== 1'b1 || done_cyc !== 4) begin
      fails++; $display("FAIL abort_restart: got %p last %p done %0d required 7 last 1 done 4",
                        got_data, got_last, done_cyc);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; base_adr = 2'd0; count = 3'd4; out_ready = 1'b1;
    #1;
    repeat (4) begin
      @(negedge clk); start = 1'b0; #1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({ram_adr, ram_rd_en, out_data, out_valid, out_last, busy, done} !== 12'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got %b required all zero",
               {ram_adr, ram_rd_en, out_data, out_valid, out_last, busy, done});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    run_xfer(2'd0, 3'd1, 1'b0, 1'b1);
    tests++;
    if (got_data.size() !== 1 || got_data[0] !== 4'hA || got_last[0] !== 1'b1) begin
      fails++; $display("FAIL reset_mid_data: got %p last %p required A last 1", got_data, got_last);
    end
    tests++;
    if (adr_log.size() !== 1 || adr_log[0] !== 2'd0 || done_cyc !== 4) begin
      fails++; $display("FAIL busy_start_ignored: got adr %p done %0d required 0 done 4", adr_log, done_cyc);
    end
  endtask

  initial begin
    mem[0] = 4'hA;
    mem[1] = 4'h3;
    mem[2] = 4'h7;
    mem[3] = 4'hC;
    test_reset();
    test_full_read();
    test_wrap();
    test_count_zero();
    test_backpressure();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
